// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: stage-register enables and clears,
// a memory-wait FSM for multi-cycle MEM accesses, and saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int unsigned MEM_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             exe_b,
  input  logic             forward_en,
  output logic             pc_en,
  output logic             if_reg_en,
  output logic             if_reg_clr,
  output logic             id_reg_en,
  output logic             id_reg_clr,
  output logic             exe_reg_en,
  output logic             mem_reg_en,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] LAST_WAIT = 4'(MEM_WAIT - 1);

  state_t     state, state_next;
  logic [3:0] wcnt, wcnt_next;
  logic       mem_op, mem_stall;
  logic       hazard, hazard_nofwd, hazard_fwd;
  logic       stall_event, flush_event;

  assign mem_op    = mem_r_en | mem_w_en;
  assign mem_stall = mem_op & (wcnt != LAST_WAIT);
  assign mem_busy  = (state == BUSY);

  assign hazard_nofwd = (exe_wb_en & (src1 == exe_dest))
                      | (mem_wb_en & (src1 == mem_dest))
                      | (two_src & ((exe_wb_en & (src2 == exe_dest))
                                  | (mem_wb_en & (src2 == mem_dest))));
  assign hazard_fwd   = exe_mem_r_en & exe_wb_en
                      & ((src1 == exe_dest) | (two_src & (src2 == exe_dest)));
  assign hazard       = forward_en ? hazard_fwd : hazard_nofwd;

  assign stall_event = !rst & (mem_stall | (hazard & !exe_b));
  assign flush_event = !rst & !mem_stall & exe_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  // Any cycle that is not a stall (op finished or op withdrawn) returns to IDLE with wcnt cleared.
  always_comb begin
    state_next = IDLE;
    wcnt_next  = '0;
    if (mem_stall) begin
      state_next = BUSY;
      wcnt_next  = wcnt + 4'd1;
    end
  end

  always_comb begin
    pc_en      = 1'b0;
    if_reg_en  = 1'b0;
    if_reg_clr = 1'b0;
    id_reg_en  = 1'b0;
    id_reg_clr = 1'b0;
    exe_reg_en = 1'b0;
    mem_reg_en = 1'b0;
    if (rst || mem_stall) begin
      // freeze: everything stays 0, a pending branch waits in EXE
    end else if (exe_b) begin
      pc_en      = 1'b1;
      if_reg_en  = 1'b1;
      if_reg_clr = 1'b1;
      id_reg_en  = 1'b1;
      id_reg_clr = 1'b1;
      exe_reg_en = 1'b1;
      mem_reg_en = 1'b1;
    end else if (hazard) begin
      id_reg_en  = 1'b1;
      id_reg_clr = 1'b1;
      exe_reg_en = 1'b1;
      mem_reg_en = 1'b1;
    end else begin
      pc_en      = 1'b1;
      if_reg_en  = 1'b1;
      id_reg_en  = 1'b1;
      exe_reg_en = 1'b1;
      mem_reg_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_event && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_event && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
